hex_keypad_input: RTL and testbench
===================================

// Module: hex_keypad_input
// PURPOSE
//  Board-side input path for the pipelined RISC-V FPGA build: the data flow from the board into the core, while the 7-seg path carries core registers out.
//  Debounces push-buttons, builds a hex word one nibble at a time from slide switches and commits it to the core.
//  The core sees the word as a memory-mapped input register with a valid/ack handshake.
//  The partial entry word is echoed for the 7-seg displays.
// PARAMETERS
//  REG_WIDTH        32      width of committed word / accumulator; multiple of 4
//  DEBOUNCE_CYCLES  500000  stable cycles before a key change is accepted (10 ms @ 50 MHz); >=2
//  SW_WIDTH         10      raw slide-switch count; only sw[3:0] are used as the nibble
// PORTS
//  clk          in   1          system clock
//  rstn         in   1          async active-low reset
//  key_n        in   3          raw buttons, active-low, asynchronous: [0]=SHIFT [1]=COMMIT [2]=CLEAR
//  sw           in   SW_WIDTH   raw slide switches, asynchronous
//  in_ack       in   1          core read strobe, 1-cycle pulse
//  in_data      out  REG_WIDTH  committed word, held while in_valid=1
//  in_valid     out  1          committed word is waiting for the core
//  entry_disp   out  12         accumulator[11:0], for the hex display
//  digit_cnt    out  $clog2(REG_WIDTH/4+1)  nibbles entered; saturates at REG_WIDTH/4
//  overrun      out  1          sticky flag, only when INPUT_OVERRUN_EN is defined; otherwise tied 0
// BEHAVIOUR
//  - Reset values: in_data=0, in_valid=0, overrun=0, accumulator=0, digit_cnt=0, all debounce counters=0, stable key state=released(1).
//  - key_n and sw each pass through a 2-flop synchronizer. sw is not debounced; its value is sampled when SHIFT is accepted.
//  - Debounce per key:
//    - counter clears whenever synced!=stable;
//    - when synced!=stable and counter==DEBOUNCE_CYCLES-1, stable<=synced.
//    - A 1->0 change of stable produces a 1-cycle press pulse. Release produces no pulse.
//    - A key held through reset yields exactly one press after DEBOUNCE_CYCLES.
//  - Press priority in one cycle: CLEAR > COMMIT > SHIFT. Lower-priority presses in that cycle are dropped.
//  - SHIFT: accum<={accum[REG_WIDTH-5:0],sw_sync[3:0]}; digit_cnt+1, saturating.
//    - Once full, further shifts discard the top nibble.
//  - CLEAR: accum<=0, digit_cnt<=0. in_data and in_valid are unaffected.
//  - FSM (entry_state_t):
//    - ENTRY: in_valid=0.
//      - COMMIT: in_data<=accum, accum<=0, digit_cnt<=0, next state HOLD.
//      - in_ack is ignored.
//    - HOLD: in_valid=1, in_data stable.
//      - in_ack alone: next state ENTRY; in_valid drops the following cycle.
//      - in_ack and COMMIT in the same cycle: in_data<=accum, stay in HOLD, no overrun.
//      - COMMIT without in_ack: see CONFIGURATION.
//  - Latency: raw key edge to press pulse = 2 sync + DEBOUNCE_CYCLES clocks. Press to register update = 1 clock.
//  - in_data and in_valid are registered outputs. entry_disp and digit_cnt are direct register outputs.
// CONFIGURATION
//  INPUT_OVERRUN_EN defined: COMMIT in HOLD without in_ack
//    - overwrites in_data with accum; accum and digit_cnt clear;
//    - sets overrun; state stays HOLD.
//    - overrun clears on the cycle after in_ack. Reset clears it.
//  INPUT_OVERRUN_EN undefined: COMMIT in HOLD without in_ack
//    - is ignored; accum is kept for a later commit;
//    - overrun is tied 0.
// STRUCTURE
//  Package fpga_io_pkg:
//    - typedef enum logic {ENTRY,HOLD} entry_state_t;
//    - localparams KEY_SHIFT=0, KEY_COMMIT=1, KEY_CLEAR=2, NUM_KEYS=3.
//  Sub-module key_debouncer(clk,rstn,key_n_raw,press):
//    - contains synchronizer, counter and edge detect;
//    - parameterised by DEBOUNCE_CYCLES; instantiated NUM_KEYS times.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1 Bounce: toggle key_n[0] every 2 clks for 20 clks, then hold 0 -> exactly one SHIFT, 6 clks after the final edge.
//  2 Entry and commit:
//    - sw=0xA,SHIFT; sw=0x5,SHIFT; sw=0xF,SHIFT -> entry_disp=0xA5F, digit_cnt=3;
//    - COMMIT -> in_data=0x00000A5F, in_valid=1, entry_disp=0.
//  3 Handshake: in HOLD pulse in_ack -> in_valid=0 next cycle; a second in_ack while in ENTRY -> no change.
//  4 Overrun:
//    - commit 0x1, enter 0x2, COMMIT with no ack;
//    - with INPUT_OVERRUN_EN -> in_data=0x2, overrun=1, cleared after in_ack;
//    - without -> in_data=0x1, entry_disp=0x002.
//  5 Priority:
//    - CLEAR+COMMIT+SHIFT in the same cycle -> accum=0, in_valid unchanged;
//    - 9 SHIFTs of 0x1..0x9 -> accum=0x23456789, digit_cnt=8.
//  6 Reset mid-operation: assert rstn=0 in HOLD with a partial entry -> all outputs 0; a held key gives one press after release.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// Shared types and key indices for the board-side input path.
package fpga_io_pkg;

  typedef enum logic {ENTRY, HOLD} entry_state_t;

  localparam int unsigned KEY_SHIFT  = 0;
  localparam int unsigned KEY_COMMIT = 1;
  localparam int unsigned KEY_CLEAR  = 2;
  localparam int unsigned NUM_KEYS   = 3;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer, stability counter and press-edge detector for one active-low button.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n_raw,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Any sample that agrees with the stable state restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = stable_q & ~stable_d;
  end

  assign press = press_q;

endmodule

// File: rtl/hex_keypad_input.sv
// Debounced hex-word entry from slide switches, committed to the core through a valid/ack register.
// Optional INPUT_OVERRUN_EN: a commit while the previous word is unread overwrites it and sets overrun.
module hex_keypad_input
  import fpga_io_pkg::*;
#(
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SW_WIDTH        = 10
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [2:0]                         key_n,
  input  logic [SW_WIDTH-1:0]                sw,
  input  logic                               in_ack,
  output logic [REG_WIDTH-1:0]               in_data,
  output logic                               in_valid,
  output logic [11:0]                        entry_disp,
  output logic [$clog2(REG_WIDTH/4+1)-1:0]   digit_cnt,
  output logic                               overrun
);

  localparam int unsigned Digits = REG_WIDTH / 4;
  localparam int unsigned DigitW = $clog2(REG_WIDTH / 4 + 1);

  logic [NUM_KEYS-1:0]  press;
  logic [3:0]           sw_meta_q, sw_sync_q;
  logic                 unused_sw;
  entry_state_t         state_q, state_d;
  logic [REG_WIDTH-1:0] accum_q, accum_d;
  logic [REG_WIDTH-1:0] in_data_q, in_data_d;
  logic                 in_valid_q, in_valid_d;
  logic [DigitW-1:0]    cnt_q, cnt_d;
  logic                 press_shift, press_commit, press_clear, commit_take;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
      .clk       (clk),
      .rstn      (rstn),
      .key_n_raw (key_n[k]),
      .press     (press[k])
    );
  end

  assign unused_sw    = ^sw[SW_WIDTH-1:4];
  assign press_shift  = press[KEY_SHIFT];
  assign press_commit = press[KEY_COMMIT];
  assign press_clear  = press[KEY_CLEAR];

`ifdef INPUT_OVERRUN_EN
  assign commit_take = press_commit;
`else
  // An unread word is protected; the entry stays in the accumulator.
  assign commit_take = press_commit && ((state_q == ENTRY) || in_ack);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      state_q    <= ENTRY;
      accum_q    <= '0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sw_meta_q  <= sw[3:0];
      sw_sync_q  <= sw_meta_q;
      state_q    <= state_d;
      accum_q    <= accum_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accum_d   = accum_q;
    in_data_d = in_data_q;
    cnt_d     = cnt_q;
    if ((state_q == HOLD) && in_ack) begin
      state_d = ENTRY;
    end
    if (press_clear) begin
      accum_d = '0;
      cnt_d   = '0;
    end else if (press_commit) begin
      if (commit_take) begin
        in_data_d = accum_q;
        accum_d   = '0;
        cnt_d     = '0;
        state_d   = HOLD;
      end
    end else if (press_shift) begin
      accum_d = {accum_q[REG_WIDTH-5:0], sw_sync_q};
      if (cnt_q != DigitW'(Digits)) begin
        cnt_d = cnt_q + DigitW'(1);
      end
    end
    in_valid_d = (state_d == HOLD);
  end

`ifdef INPUT_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if ((state_q == HOLD) && in_ack) begin
      overrun_d = 1'b0;
    end else if ((state_q == HOLD) && press_commit && !press_clear) begin
      overrun_d = 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign in_data    = in_data_q;
  assign in_valid   = in_valid_q;
  assign entry_disp = accum_q[11:0];
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_hex_keypad_input.sv
// Scoreboard bench for hex_keypad_input: every observed output change is matched against a queue.
module tb_hex_keypad_input;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned DEB       = 4;
  localparam int unsigned SWW       = 10;

`ifdef INPUT_OVERRUN_EN
  localparam logic [31:0] LastData = 32'h2;
`else
  localparam logic [31:0] LastData = 32'h1;
`endif

  typedef struct packed {
    logic        ov;
    logic        v;
    logic [31:0] data;
    logic [11:0] disp;
    logic [3:0]  cnt;
  } snap_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [2:0]     key_n = 3'b111;
  logic [SWW-1:0] sw = '0;
  logic           in_ack = 1'b0;
  logic [31:0]    in_data;
  logic           in_valid;
  logic [11:0]    entry_disp;
  logic [3:0]     digit_cnt;
  logic           overrun;

  snap_t cur;
  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  hex_keypad_input #(
    .REG_WIDTH       (REG_WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .SW_WIDTH        (SWW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_n      (key_n),
    .sw         (sw),
    .in_ack     (in_ack),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .entry_disp (entry_disp),
    .digit_cnt  (digit_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  assign cur = {overrun, in_valid, in_data, entry_disp, digit_cnt};

  // Monitor: each change of the output snapshot consumes one expected entry.
  initial begin
    snap_t prev;
    snap_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en && (cur !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got=%h expected=no change", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL out_snapshot got=%h expected=%h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ov, input logic v, input logic [31:0] data,
                      input logic [11:0] disp, input logic [3:0] cnt);
    exp_q.push_back({ov, v, data, disp, cnt});
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic keys(input logic [2:0] mask, input logic [3:0] nib);
    sw[3:0] = nib;
    key_n   = ~mask;
    tick(DEB + 8);
    key_n   = 3'b111;
    tick(DEB + 8);
  endtask

  task automatic ack();
    in_ack = 1'b1;
    tick(1);
    in_ack = 1'b0;
    tick(3);
  endtask

  initial begin
    int n;
    logic [31:0] shift_exp [9];
    shift_exp = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345, 32'h123456,
                  32'h1234567, 32'h12345678, 32'h23456789};

    tick(4);
    @(negedge clk);
    chk("reset_outputs", 64'(cur), 64'(0));
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Bounce: only the final settled low level is accepted.
    sw[3:0] = 4'hA;
    push(0, 0, 32'h0, 12'h00A, 4'd1);
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      tick(2);
    end
    key_n[0] = 1'b0;
    n = 0;
    while (digit_cnt == 4'd0 && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("shift_latency", 64'(n), 64'(7));
    tick(10);
    key_n[0] = 1'b1;
    tick(12);

    // Entry and commit.
    push(0, 0, 32'h0, 12'h0A5, 4'd2);
    keys(3'b001, 4'h5);
    push(0, 0, 32'h0, 12'hA5F, 4'd3);
    keys(3'b001, 4'hF);
    push(0, 1, 32'h00000A5F, 12'h000, 4'd0);
    keys(3'b010, 4'h0);

    // Handshake; the second ack in ENTRY must change nothing.
    push(0, 0, 32'h00000A5F, 12'h000, 4'd0);
    ack();
    ack();
    chk("valid_after_ack", 64'(in_valid), 64'(0));

    // Commit while the previous word is unread.
    push(0, 0, 32'h00000A5F, 12'h001, 4'd1);
    keys(3'b001, 4'h1);
    push(0, 1, 32'h1, 12'h000, 4'd0);
    keys(3'b010, 4'h0);
    push(0, 1, 32'h1, 12'h002, 4'd1);
    keys(3'b001, 4'h2);
`ifdef INPUT_OVERRUN_EN
    push(1, 1, 32'h2, 12'h000, 4'd0);
    keys(3'b010, 4'h0);
    chk("overrun_set", 64'(overrun), 64'(1));
    push(0, 0, 32'h2, 12'h000, 4'd0);
    ack();
`else
    keys(3'b010, 4'h0);
    chk("data_kept", 64'(in_data), 64'(32'h1));
    chk("entry_kept", 64'(entry_disp), 64'(12'h002));
    push(0, 0, 32'h1, 12'h002, 4'd1);
    ack();
    push(0, 0, 32'h1, 12'h000, 4'd0);
    keys(3'b100, 4'h0);
`endif

    // Priority: CLEAR beats COMMIT and SHIFT.
    push(0, 0, LastData, 12'h003, 4'd1);
    keys(3'b001, 4'h3);
    push(0, 0, LastData, 12'h000, 4'd0);
    keys(3'b111, 4'h9);
    chk("prio_valid", 64'(in_valid), 64'(0));
    for (int i = 0; i < 9; i++) begin
      push(0, 0, LastData, shift_exp[i][11:0], (i < 8) ? 4'(i + 1) : 4'd8);
      keys(3'b001, 4'(i + 1));
    end
    push(0, 1, 32'h23456789, 12'h000, 4'd0);
    keys(3'b010, 4'h0);

    // Reset in HOLD with a partial entry and a key held throughout.
    push(0, 1, 32'h23456789, 12'h00C, 4'd1);
    keys(3'b001, 4'hC);
    sw[3:0]  = 4'h7;
    key_n[0] = 1'b0;
    tick(3);
    push(0, 0, 32'h0, 12'h000, 4'd0);
    rstn = 1'b0;
    #1;
    chk("async_reset", 64'(cur), 64'(0));
    tick(3);
    rstn = 1'b1;
    push(0, 0, 32'h0, 12'h007, 4'd1);
    tick(25);
    key_n[0] = 1'b1;
    tick(15);
    chk("held_key_once", 64'(digit_cnt), 64'(1));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
